// File: rtl/serial_arith_pkg.sv
// Shared state encodings for the bit-serial arithmetic units.
package serial_arith_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        SHIFT = ENC_SHIFT,
        DONE  = ENC_DONE
    } ser_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell (module full_subtractor).
// With SERIAL_SUBTRACTOR_ADD_EN defined, a mode input selects full-adder behaviour.
module full_subtractor (
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    input  logic mode,
`endif
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic axb;

    assign axb = a ^ b;
    assign d   = axb ^ bin;

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    // bin/bo double as carry-in/carry-out when adding
    assign bo = mode ? ((a & b) | (bin & axb))
                     : ((~a & b) | (~axb & bin));
`else
    assign bo = (~a & b) | (~axb & bin);
`endif

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through one full-subtractor cell.
// Optional macro SERIAL_SUBTRACTOR_ADD_EN adds a `mode` input (1 = add, 0 = subtract).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             cell_d;
    logic             cell_bo;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    logic             mode_q;
`endif

    full_subtractor u_cell (
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        .mode (mode_q),
`endif
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bo   (cell_bo)
    );

    // New bit enters at the MSB so the LSB-first result ends up aligned after WIDTH shifts
    assign res_d = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
                        mode_q   <= mode;
`endif
                    end
                end
                SHIFT: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= cell_bo;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result is published with the done pulse and held until the next completion
                    diff_q  <= res_q;
                    bout_q  <= borrow_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Build with SERIAL_SUBTRACTOR_ADD_EN defined to also exercise the add mode.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    logic       mode;
`endif

    int vectors;
    int miscompares;
    int lat;
    logic [7:0] resD;
    logic       resB;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        .mode  (mode),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands with a one-cycle start; returns #1 after the accepting edge
    task automatic startOp(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges since the accepting edge, 0 on timeout
    task automatic waitDone(input int elapsed);
        lat = 0;
        for (int k = elapsed + 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        resD = diff;
        resB = bout;
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
        startOp(av, bv);
        waitDone(0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset: busy=%b done=%b diff=%h bout=%b, want all zero", busy, done, diff, bout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] va [4] = '{8'd5, 8'd3, 8'd0, 8'hFF};
        logic [7:0] vb [4] = '{8'd3, 8'd5, 8'd0, 8'hFF};
        logic [7:0] ed [4] = '{8'h02, 8'hFE, 8'h00, 8'h00};
        logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            startOp(va[i], vb[i]);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL busy_after_accept[%0d]: got %b, want 1", i, busy);
            end
            waitDone(1 - 1);
            vectors++;
            if (lat !== 9) begin
                miscompares++;
                $display("[TB] FAIL latency[%0d]: got %0d, want 9", i, lat);
            end
            vectors++;
            if (resD !== ed[i] || resB !== eb[i]) begin
                miscompares++;
                $display("[TB] FAIL result[%0d] %0d-%0d: got diff=%h bout=%b, want diff=%h bout=%b",
                         i, va[i], vb[i], resD, resB, ed[i], eb[i]);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || diff !== ed[i]) begin
                miscompares++;
                $display("[TB] FAIL pulse_hold[%0d]: got done=%b diff=%h, want done=0 diff=%h", i, done, diff, ed[i]);
            end
        end
    endtask

    task automatic test_borrow_ripple;
        applyStimulus(8'd0, 8'd1);
        vectors++;
        if (lat !== 9 || resD !== 8'hFF || resB !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ripple 0-1: got lat=%0d diff=%h bout=%b, want lat=9 diff=ff bout=1", lat, resD, resB);
        end
    endtask

    task automatic test_ignore_start;
        int extra;
        startOp(8'd100, 8'd30);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(4);
        vectors++;
        if (lat !== 9 || resD !== 8'd70 || resB !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_start: got lat=%0d diff=%0d bout=%b, want lat=9 diff=70 bout=0", lat, resD, resB);
        end
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        vectors++;
        if (extra !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_done: got %0d extra pulses busy=%b, want 0 and busy=0", extra, busy);
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        startOp(8'd50, 8'd20);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_state: busy=%b done=%b diff=%h bout=%b, want all zero", busy, done, diff, bout);
        end
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles, want 0", pulses);
        end
        applyStimulus(8'd7, 8'd2);
        vectors++;
        if (lat !== 9 || resD !== 8'd5 || resB !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_abort 7-2: got lat=%0d diff=%0d bout=%b, want lat=9 diff=5 bout=0", lat, resD, resB);
        end
    endtask

    task automatic test_back_to_back;
        applyStimulus(8'h80, 8'h01);
        vectors++;
        if (resD !== 8'h7F || resB !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got diff=%h bout=%b, want diff=7f bout=0", resD, resB);
        end
        startOp(8'h10, 8'h20);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (busy !== 1'b1 || diff !== 8'h7F) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold: got busy=%b diff=%h, want busy=1 diff=7f", busy, diff);
        end
        waitDone(3);
        vectors++;
        if (lat !== 9 || resD !== 8'hF0 || resB !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got lat=%0d diff=%h bout=%b, want lat=9 diff=f0 bout=1", lat, resD, resB);
        end
    endtask

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    task automatic test_add_mode;
        mode = 1'b1;
        applyStimulus(8'd200, 8'd100);
        mode = 1'b0;
        vectors++;
        if (lat !== 9 || resD !== 8'd44 || resB !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL add 200+100: got lat=%0d diff=%0d bout=%b, want lat=9 diff=44 bout=1", lat, resD, resB);
        end
        applyStimulus(8'd200, 8'd100);
        vectors++;
        if (lat !== 9 || resD !== 8'd100 || resB !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sub 200-100: got lat=%0d diff=%0d bout=%b, want lat=9 diff=100 bout=0", lat, resD, resB);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        mode = 1'b0;
`endif
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        test_add_mode();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
